// File: rtl/view_controller_pkg.sv
// Shared constants, key indices and FSM encoding for the fractal-view navigation controller.
package view_controller_pkg;

    localparam int WIDTH      = 20;
    localparam int FRACTIONAL = 16;

    localparam int KEY_XP = 0;
    localparam int KEY_YM = 1;
    localparam int KEY_YP = 2;
    localparam int KEY_XM = 3;

    localparam logic [3:0] ZOOM_DEFAULT = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        MUL,
        DONE
    } state_e;

    // Highest set switch wins: bit8 -> 1 ... bit0 -> 9; none set -> default.
    function automatic logic [3:0] decode_zoom(input logic [8:0] sw);
        logic [3:0] z;
        z = ZOOM_DEFAULT;
        for (int i = 0; i < 9; i++) begin
            if (sw[i]) z = 4'(9 - i);
        end
        return z;
    endfunction

endpackage

// File: rtl/view_controller_key_debounce_repeat.sv
// One pan key: 2-FF synchronizer, counter debouncer and auto-repeat timer.
// Emits a single-cycle step on the press edge and every REPEAT_PERIOD cycles while held.
module key_debounce_repeat #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REPEAT_PERIOD   = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic step
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_W = (REPEAT_PERIOD > 2) ? $clog2(REPEAT_PERIOD) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            step_q, step_d;
    logic            press_edge;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        sync1_d    = key_n;
        sync2_d    = sync1_q;
        stable_d   = stable_q;
        db_cnt_d   = '0;
        rep_cnt_d  = '0;
        step_d     = 1'b0;

        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) stable_d = ~stable_q;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end

        press_edge = stable_q & ~stable_d;

        if (press_edge) begin
            step_d = 1'b1;
        end else if (!stable_q && !stable_d) begin
            if (rep_cnt_q == RP_LAST) step_d = 1'b1;
            else                      rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            stable_q  <= 1'b1;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            step_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            step_q    <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/view_controller.sv
// Fractal view navigation: pan-key stepping, saturating delta accumulation, frame-synchronous
// commit of offsets/zoom and a 4-cycle shift-add multiply for the zoom-scaled offsets.
module view_controller
    import view_controller_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 65536,
    parameter int               REPEAT_PERIOD   = 256,
    parameter logic [WIDTH-1:0] X_OFFSET_INIT   = 20'h6A800,
    parameter logic [WIDTH-1:0] Y_OFFSET_INIT   = 20'h3C000,
    parameter int               DELTA_MAX       = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       keys,
    input  logic [17:0]      zoom_level,
    input  logic             frame_start,
    output logic [WIDTH-1:0] x_offset,
    output logic [WIDTH-1:0] y_offset,
    output logic [3:0]       zoom,
    output logic [WIDTH-1:0] x_offset_zoom,
    output logic [WIDTH-1:0] y_offset_zoom,
    output logic             view_updated,
    output logic             busy
);

    localparam logic [WIDTH-1:0] XZ_INIT = WIDTH'(X_OFFSET_INIT * ZOOM_DEFAULT);
    localparam logic [WIDTH-1:0] YZ_INIT = WIDTH'(Y_OFFSET_INIT * ZOOM_DEFAULT);

    logic [3:0] steps;
    logic       unused_zoom_bits;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce_repeat #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_key (
            .clk  (clk),
            .rst  (rst),
            .key_n(keys[i]),
            .step (steps[i])
        );
    end

    assign unused_zoom_bits = ^zoom_level[17:9];

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_offset_q, x_offset_d, y_offset_q, y_offset_d;
    logic [WIDTH-1:0]  xz_q, xz_d, yz_q, yz_d;
    logic [3:0]        zoom_q, zoom_d;
    logic signed [7:0] dx_q, dx_d, dy_q, dy_d;
    logic [WIDTH-1:0]  mcand_x_q, mcand_x_d, mcand_y_q, mcand_y_d;
    logic [WIDTH-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [3:0]        mplier_q, mplier_d;
    logic [1:0]        mul_cnt_q, mul_cnt_d;

    function automatic logic signed [7:0] sat_step(input logic signed [7:0] d,
                                                   input logic inc, input logic dec);
        int s;
        s = int'(d) + (inc ? 1 : 0) - (dec ? 1 : 0);
        if (s > DELTA_MAX)       s = DELTA_MAX;
        else if (s < -DELTA_MAX) s = -DELTA_MAX;
        return 8'(s);
    endfunction

    always_comb begin
        state_d    = state_q;
        x_offset_d = x_offset_q;
        y_offset_d = y_offset_q;
        xz_d       = xz_q;
        yz_d       = yz_q;
        zoom_d     = zoom_q;
        mcand_x_d  = mcand_x_q;
        mcand_y_d  = mcand_y_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        mplier_d   = mplier_q;
        mul_cnt_d  = mul_cnt_q;
        dx_d       = sat_step(dx_q, steps[KEY_XP], steps[KEY_XM]);
        dy_d       = sat_step(dy_q, steps[KEY_YP], steps[KEY_YM]);

        unique case (state_q)
            IDLE: begin
                if (frame_start) state_d = APPLY;
            end
            APPLY: begin
                x_offset_d = x_offset_q + {{(WIDTH-8){dx_q[7]}}, dx_q};
                y_offset_d = y_offset_q + {{(WIDTH-8){dy_q[7]}}, dy_q};
                zoom_d     = decode_zoom(zoom_level[8:0]);
                // Steps landing in the commit cycle start the next accumulation.
                dx_d       = sat_step(8'sd0, steps[KEY_XP], steps[KEY_XM]);
                dy_d       = sat_step(8'sd0, steps[KEY_YP], steps[KEY_YM]);
                mcand_x_d  = x_offset_d;
                mcand_y_d  = y_offset_d;
                mplier_d   = zoom_d;
                acc_x_d    = '0;
                acc_y_d    = '0;
                mul_cnt_d  = '0;
                state_d    = MUL;
            end
            MUL: begin
                acc_x_d   = mplier_q[0] ? acc_x_q + mcand_x_q : acc_x_q;
                acc_y_d   = mplier_q[0] ? acc_y_q + mcand_y_q : acc_y_q;
                mcand_x_d = mcand_x_q << 1;
                mcand_y_d = mcand_y_q << 1;
                mplier_d  = mplier_q >> 1;
                if (mul_cnt_q == 2'd3) begin
                    xz_d    = acc_x_d;
                    yz_d    = acc_y_d;
                    state_d = DONE;
                end else begin
                    mul_cnt_d = mul_cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_offset_q <= X_OFFSET_INIT;
            y_offset_q <= Y_OFFSET_INIT;
            xz_q       <= XZ_INIT;
            yz_q       <= YZ_INIT;
            zoom_q     <= ZOOM_DEFAULT;
            dx_q       <= '0;
            dy_q       <= '0;
            mcand_x_q  <= '0;
            mcand_y_q  <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            mplier_q   <= '0;
            mul_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            x_offset_q <= x_offset_d;
            y_offset_q <= y_offset_d;
            xz_q       <= xz_d;
            yz_q       <= yz_d;
            zoom_q     <= zoom_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            mcand_x_q  <= mcand_x_d;
            mcand_y_q  <= mcand_y_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            mplier_q   <= mplier_d;
            mul_cnt_q  <= mul_cnt_d;
        end
    end

    assign x_offset      = x_offset_q;
    assign y_offset      = y_offset_q;
    assign zoom          = zoom_q;
    assign x_offset_zoom = xz_q;
    assign y_offset_zoom = yz_q;
    assign view_updated  = (state_q == DONE);
    assign busy          = (state_q != IDLE);

endmodule
